// File: rtl/fastreadout_pkg.sv
// fastreadout_pkg: shared constants and types for the
// measurement readout path.
package fastreadout_pkg;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_SEQ,
    ST_PAYLOAD,
    ST_CSUM
  } state_t;

  function automatic int frame_len(input int width);
    return 3 + 3 * (width / 8);
  endfunction

endpackage

// File: rtl/meas_snapshot_buf.sv
// meas_snapshot_buf: frame snapshot, one-deep pending
// buffer and saturating overrun counter.
module meas_snapshot_buf
  import fastreadout_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               meas_valid,
  input  logic               idle,
  input  logic               frame_end,
  input  logic [WIDTH-1:0]   period,
  input  logic [WIDTH-1:0]   time_high,
  input  logic [WIDTH-1:0]   time_low,
  output logic [3*WIDTH-1:0] snap,
  output logic               pend_full,
  output logic [7:0]         drop_count
);

  logic [3*WIDTH-1:0] pend;
  logic [3*WIDTH-1:0] meas;
  logic cap_direct;
  logic promote;
  logic to_pend;
  logic drop;

  assign meas = {period, time_high, time_low};

  // A strobe at frame end with pending full keeps
  // pending occupied without counting a drop.
  assign cap_direct = meas_valid &
    (idle | (frame_end & ~pend_full));
  assign promote = frame_end & pend_full;
  assign to_pend = meas_valid & ~cap_direct;
  assign drop    = to_pend & pend_full & ~promote;

  always_ff @(posedge clk) begin
    if (rst) begin
      snap       <= '0;
      pend       <= '0;
      pend_full  <= 1'b0;
      drop_count <= '0;
    end else begin
      if (cap_direct)
        snap <= meas;
      else if (promote)
        snap <= pend;
      if (to_pend)
        pend <= meas;
      if (promote)
        pend_full <= to_pend;
      else if (to_pend)
        pend_full <= 1'b1;
      if (drop && drop_count != 8'hFF)
        drop_count <= drop_count + 8'd1;
    end
  end

endmodule

// File: rtl/meas_frame_serializer.sv
// meas_frame_serializer: frames measurement snapshots
// and streams them bytewise over valid/ready.
module meas_frame_serializer
  import fastreadout_pkg::*;
#(
  parameter int         WIDTH     = 32,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             MEAS_VALID,
  input  logic [WIDTH-1:0] PERIOD,
  input  logic [WIDTH-1:0] TIME_HIGH,
  input  logic [WIDTH-1:0] TIME_LOW,
  output logic [7:0]       OUT_DATA,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic             BUSY,
  output logic [7:0]       DROP_COUNT
);

  localparam int FLEN = frame_len(WIDTH);
  localparam int NPAY = FLEN - 3;
  localparam int IW   = $clog2(NPAY);
  localparam logic [IW-1:0] LAST = IW'(NPAY - 1);

  state_t state, state_n;
  logic [IW-1:0] idx, idx_n, sel;
  logic [7:0] seq, frame_seq;
  logic [7:0] csum, csum_n;
  logic [7:0] data_n, pay_byte;
  logic [3*WIDTH-1:0] snap;
  logic hs, idle, frame_end;
  logic pend_full, start;

  assign hs        = OUT_VALID & OUT_READY;
  assign idle      = (state == ST_IDLE);
  assign frame_end = (state == ST_CSUM) & hs;
  assign start     = (idle & MEAS_VALID) |
    (frame_end & (pend_full | MEAS_VALID));

  meas_snapshot_buf #(.WIDTH(WIDTH)) u_buf (
    .clk        (CLK),
    .rst        (RST),
    .meas_valid (MEAS_VALID),
    .idle       (idle),
    .frame_end  (frame_end),
    .period     (PERIOD),
    .time_high  (TIME_HIGH),
    .time_low   (TIME_LOW),
    .snap       (snap),
    .pend_full  (pend_full),
    .drop_count (DROP_COUNT)
  );

  // Byte to present after the current handshake.
  assign sel = (state == ST_SEQ) ? '0 : idx + IW'(1);

  always_comb begin
    pay_byte = '0;
    for (int i = 0; i < NPAY; i++)
      if (sel == IW'(i))
        pay_byte = snap[(NPAY-1-i)*8 +: 8];
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    data_n  = OUT_DATA;
    csum_n  = csum;
    unique case (state)
      ST_IDLE: begin
        if (MEAS_VALID) begin
          state_n = ST_SYNC;
          data_n  = SYNC_BYTE;
        end
      end
      ST_SYNC: begin
        if (hs) begin
          state_n = ST_SEQ;
          data_n  = frame_seq;
        end
      end
      ST_SEQ: begin
        if (hs) begin
          state_n = ST_PAYLOAD;
          idx_n   = '0;
          data_n  = pay_byte;
          csum_n  = OUT_DATA;
        end
      end
      ST_PAYLOAD: begin
        if (hs) begin
          csum_n = csum ^ OUT_DATA;
          if (idx == LAST) begin
            state_n = ST_CSUM;
            data_n  = csum ^ OUT_DATA;
          end else begin
            idx_n  = sel;
            data_n = pay_byte;
          end
        end
      end
      ST_CSUM: begin
        if (hs) begin
          if (pend_full | MEAS_VALID) begin
            state_n = ST_SYNC;
            data_n  = SYNC_BYTE;
          end else begin
            state_n = ST_IDLE;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= ST_IDLE;
      idx       <= '0;
      OUT_DATA  <= '0;
      OUT_VALID <= 1'b0;
      BUSY      <= 1'b0;
      seq       <= '0;
      frame_seq <= '0;
      csum      <= '0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      OUT_DATA  <= data_n;
      OUT_VALID <= (state_n != ST_IDLE);
      BUSY      <= (state_n != ST_IDLE);
      csum      <= csum_n;
      if (start) begin
        frame_seq <= seq;
        seq       <= seq + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_meas_frame_serializer.sv
// tb_meas_frame_serializer: scoreboard bench for the
// measurement frame serializer.
`timescale 1ns/1ps
module tb_meas_frame_serializer;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        MEAS_VALID = 1'b0;
  logic        OUT_READY = 1'b1;
  logic [31:0] PERIOD = '0;
  logic [31:0] TIME_HIGH = '0;
  logic [31:0] TIME_LOW = '0;
  logic [7:0]  OUT_DATA;
  logic [7:0]  DROP_COUNT;
  logic        OUT_VALID;
  logic        BUSY;

  int n_cmp = 0;
  int n_bad = 0;
  int acc_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] seq_m = 8'd0;
  bit rnd = 1'b0;
  logic stalled = 1'b0;
  logic [7:0] held = '0;

  always #5 CLK = ~CLK;

  meas_frame_serializer #(
    .WIDTH(32),
    .SYNC_BYTE(8'hA5)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .MEAS_VALID (MEAS_VALID),
    .PERIOD     (PERIOD),
    .TIME_HIGH  (TIME_HIGH),
    .TIME_LOW   (TIME_LOW),
    .OUT_DATA   (OUT_DATA),
    .OUT_VALID  (OUT_VALID),
    .OUT_READY  (OUT_READY),
    .BUSY       (BUSY),
    .DROP_COUNT (DROP_COUNT)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic push_frame(input logic [31:0] p,
                            input logic [31:0] h,
                            input logic [31:0] l);
    logic [95:0] v;
    logic [7:0] b, cs;
    v = {p, h, l};
    exp_q.push_back(8'hA5);
    exp_q.push_back(seq_m);
    cs = seq_m;
    for (int i = 0; i < 12; i++) begin
      b = v[95-8*i -: 8];
      exp_q.push_back(b);
      cs ^= b;
    end
    exp_q.push_back(cs);
    seq_m++;
  endtask

  task automatic meas(input logic [31:0] p,
                      input logic [31:0] h,
                      input logic [31:0] l,
                      input bit push);
    @(posedge CLK); #1;
    MEAS_VALID = 1'b1;
    PERIOD     = p;
    TIME_HIGH  = h;
    TIME_LOW   = l;
    if (push) push_frame(p, h, l);
    @(posedge CLK); #1;
    MEAS_VALID = 1'b0;
  endtask

  task automatic wait_acc(input int n);
    int t = 0;
    while (acc_cnt < n && t < 200) begin
      @(posedge CLK); #1;
      t++;
    end
    if (acc_cnt < n) chk("acc_timeout", acc_cnt, n);
  endtask

  task automatic wait_idle(output int gaps);
    int t = 0;
    gaps = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      @(posedge CLK); #1;
      OUT_READY = rnd ? ($urandom_range(0, 99) < 30)
                      : 1'b1;
      if (!OUT_VALID && exp_q.size() != 0) gaps++;
      t++;
    end
    if (exp_q.size() != 0) begin
      chk("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  always @(negedge CLK) begin
    if (!RST) begin
      if (stalled) begin
        chk("stall_hold", OUT_DATA, held);
        chk("stall_valid", OUT_VALID, 1);
      end
      if (OUT_VALID && OUT_READY) begin
        if (exp_q.size() == 0)
          chk("extra_byte", exp_q.size(), 1);
        else
          chk("byte", OUT_DATA, exp_q.pop_front());
        acc_cnt++;
      end
      stalled = OUT_VALID && !OUT_READY;
      held    = OUT_DATA;
    end else begin
      stalled = 1'b0;
    end
  end

  initial begin
    logic [7:0] golden [15];
    int gaps;
    int base;
    golden = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h01,
               8'h2C, 8'h00, 8'h00, 8'h00, 8'h96,
               8'h00, 8'h00, 8'h00, 8'h96, 8'h2D};

    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    chk("rst_valid", OUT_VALID, 0);
    chk("rst_data", OUT_DATA, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_drop", DROP_COUNT, 0);

    // single frame against the literal byte table
    foreach (golden[i]) exp_q.push_back(golden[i]);
    seq_m++;
    meas(32'h12C, 32'h96, 32'h96, 1'b0);
    chk("lat_valid", OUT_VALID, 1);
    chk("lat_sync", OUT_DATA, 8'hA5);
    chk("busy_on", BUSY, 1);
    wait_idle(gaps);
    chk("gap_single", gaps, 0);
    chk("end_valid", OUT_VALID, 0);
    chk("end_busy", BUSY, 0);

    // backpressure
    rnd = 1'b1;
    OUT_READY = 1'b0;
    meas(32'h12C, 32'h96, 32'h96, 1'b1);
    wait_idle(gaps);
    rnd = 1'b0;
    OUT_READY = 1'b1;
    chk("bp_idle", OUT_VALID, 0);

    // pending buffer, no gap between frames
    base = acc_cnt;
    meas(32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 1'b1);
    wait_acc(base + 5);
    meas(32'h00000010, 32'h00000020, 32'h00000030, 1'b1);
    wait_idle(gaps);
    chk("pend_gap", gaps, 0);
    chk("pend_drop", DROP_COUNT, 0);
    chk("pend_busy", BUSY, 0);

    // overrun: third strobe overwrites the second
    meas(32'h11111111, 32'h22222222, 32'h33333333, 1'b1);
    meas(32'h44444444, 32'h55555555, 32'h66666666, 1'b0);
    chk("ovr_drop0", DROP_COUNT, 0);
    meas(32'h77777777, 32'h88888888, 32'h99999999, 1'b1);
    chk("ovr_drop1", DROP_COUNT, 1);
    wait_idle(gaps);
    chk("ovr_drop_end", DROP_COUNT, 1);

    // reset mid-frame
    base = acc_cnt;
    meas(32'hCAFEF00D, 32'h0BADC0DE, 32'h12345678, 1'b1);
    wait_acc(base + 7);
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    exp_q.delete();
    seq_m = 8'd0;
    chk("mid_rst_valid", OUT_VALID, 0);
    chk("mid_rst_busy", BUSY, 0);
    chk("mid_rst_drop", DROP_COUNT, 0);

    // SEQ wrap over 257 frames
    for (int i = 0; i < 257; i++) begin
      meas(32'(i), 32'(i * 3), ~32'(i), 1'b1);
      wait_idle(gaps);
    end
    chk("wrap_idle", BUSY, 0);

    // drop counter saturation
    OUT_READY = 1'b0;
    meas(32'hAAAA0000, 32'hBBBB0000, 32'hCCCC0000, 1'b1);
    meas(32'h1, 32'h2, 32'h3, 1'b0);
    for (int i = 0; i < 300; i++) begin
      meas(32'(i), 32'(i + 7), 32'(i ^ 5), i == 299);
      if (i == 254) chk("sat_255", DROP_COUNT, 255);
    end
    chk("sat_hold", DROP_COUNT, 255);
    wait_idle(gaps);
    chk("sat_end", DROP_COUNT, 255);
    chk("sat_idle", OUT_VALID, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
